pu_riscv_mmu_arbiter: RTL and testbench
=======================================

# pu_riscv_mmu_arbiter

Two-requester arbiter that shares the single CPU-side port of the memory management unit between the instruction-fetch path and the data-access path. It selects one requester at a time, holds the winner's request attributes stable toward the MMU until the MMU acknowledges, then returns the acknowledge and read data to the winner only. It sits between the core's fetch/LSU request logic and the MMU.

## Interface
Parameters:
- XLEN, 64, address/data width of all request and response buses

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  abort any in-flight grant (pipeline flush)
- ireq_i  in  1  instruction-side request, held until iack_o
- iadr_i  in  XLEN  instruction virtual address
- isize_i  in  3  instruction access size
- iprot_i  in  3  instruction protection attributes
- iack_o  out  1  instruction-side acknowledge
- iq_o  out  XLEN  instruction read data, valid with iack_o
- dreq_i  in  1  data-side request, held until dack_o
- dadr_i  in  XLEN  data virtual address
- dsize_i  in  3  data access size
- dlock_i  in  1  locked (atomic) data access
- dprot_i  in  3  data protection attributes
- dwe_i  in  1  data write enable
- dd_i  in  XLEN  data write data
- dack_o  out  1  data-side acknowledge
- dq_o  out  XLEN  data read data, valid with dack_o
- vreq_o  out  1  request to MMU
- vadr_o, vsize_o, vlock_o, vprot_o, vwe_o, vd_o  out  XLEN/3/1/3/1/XLEN  request attributes to MMU
- vq_i  in  XLEN  MMU read data
- vack_i  in  1  MMU acknowledge, one cycle per transaction

## Operation
- FSM states: IDLE, GNT_I, GNT_D. Reset state IDLE.
- IDLE: if no request, stay. If only one of ireq_i/dreq_i, grant it. If both: if lock_hold set, grant data; else grant the side not granted last (last_gnt register, reset = data, so instruction wins first tie).
- On grant: register request attributes into vadr_o/vsize_o/vprot_o/vwe_o/vd_o/vlock_o; instruction grant forces vwe_o=0, vlock_o=0, vd_o=0. Set vreq_o=1, update last_gnt.
- GNT_x: vreq_o held 1, attributes held constant. On vack_i: pulse x-side ack, go IDLE, vreq_o=0.
- lock_hold: set on data ack when vlock_o=1 and dlock_i=1; cleared on next data grant or when dlock_i low in IDLE. Guarantees a locked sequence is not split by instruction fetches.
- iack_o = vack_i & (state==GNT_I); dack_o = vack_i & (state==GNT_D); iq_o/dq_o = vq_i (qualify with ack only).
- vack_i in IDLE: ignored, no ack forwarded.
- clr_i (highest priority): from any state go IDLE, vreq_o=0 next cycle, lock_hold cleared, no ack forwarded even if vack_i coincides; last_gnt unchanged. clr_i in IDLE blocks granting that cycle.
- Reset mid-transaction: immediate return to IDLE, all outputs to reset values.

## Timing
- Reset values: vreq_o=0, all v* attribute outputs 0, iack_o=dack_o=0, last_gnt=data, lock_hold=0.
- Request seen in IDLE at cycle N -> vreq_o=1 and attributes valid from N+1.
- Ack is combinational: iack_o/dack_o in the same cycle as vack_i.
- After ack, one IDLE cycle before next grant; max throughput one transaction per (MMU latency + 1) cycles.
- Requester must keep req and attributes stable until its ack; arbiter does not sample attributes after grant.

## Test plan
- Instruction only: ireq_i=1, iadr_i=0x1000, vack_i two cycles after vreq_o rises, vq_i=0xDEAD -> vadr_o=0x1000, vwe_o=0, iack_o=1 with iq_o=0xDEAD, dack_o=0.
- Simultaneous from reset: ireq_i=dreq_i=1 held -> grants I, D, I, D in order; each ack routed only to granted side.
- Locked data: dreq_i=1, dlock_i=1, ireq_i=1 for three data transactions -> all three data grants consecutive, instruction granted after dlock_i drops.
- Flush: clr_i pulsed while GNT_D with vack_i=1 same cycle -> dack_o=0, vreq_o=0 next cycle, state IDLE.
- Stray ack: vack_i=1 in IDLE -> iack_o=dack_o=0, no state change.
- Async reset asserted mid GNT_I -> vreq_o and all attributes 0 immediately, first tie after release goes to instruction.

Source files
------------

// File: rtl/pu_riscv_mmu_arbiter_if.sv
// CPU-side request/response bundle shared by the fetch path, the LSU path and the MMU port.
// The slave view belongs to the arbiter; the master view drives requests and MMU responses.
interface pu_riscv_mmu_arbiter_if #(
    parameter int XLEN = 64
);
    logic            ireq_i;
    logic [XLEN-1:0] iadr_i;
    logic [2:0]      isize_i;
    logic [2:0]      iprot_i;
    logic            iack_o;
    logic [XLEN-1:0] iq_o;

    logic            dreq_i;
    logic [XLEN-1:0] dadr_i;
    logic [2:0]      dsize_i;
    logic            dlock_i;
    logic [2:0]      dprot_i;
    logic            dwe_i;
    logic [XLEN-1:0] dd_i;
    logic            dack_o;
    logic [XLEN-1:0] dq_o;

    logic            vreq_o;
    logic [XLEN-1:0] vadr_o;
    logic [2:0]      vsize_o;
    logic            vlock_o;
    logic [2:0]      vprot_o;
    logic            vwe_o;
    logic [XLEN-1:0] vd_o;
    logic [XLEN-1:0] vq_i;
    logic            vack_i;

    modport slave (
        input  ireq_i, iadr_i, isize_i, iprot_i,
        output iack_o, iq_o,
        input  dreq_i, dadr_i, dsize_i, dlock_i, dprot_i, dwe_i, dd_i,
        output dack_o, dq_o,
        output vreq_o, vadr_o, vsize_o, vlock_o, vprot_o, vwe_o, vd_o,
        input  vq_i, vack_i
    );

    modport master (
        output ireq_i, iadr_i, isize_i, iprot_i,
        input  iack_o, iq_o,
        output dreq_i, dadr_i, dsize_i, dlock_i, dprot_i, dwe_i, dd_i,
        input  dack_o, dq_o,
        input  vreq_o, vadr_o, vsize_o, vlock_o, vprot_o, vwe_o, vd_o,
        output vq_i, vack_i
    );
endinterface

// File: rtl/pu_riscv_mmu_arbiter.sv
// Shares the single MMU request port between instruction fetch and data access.
// Round-robin on ties, with locked data sequences kept together until dlock_i drops.
module pu_riscv_mmu_arbiter #(
    parameter int XLEN = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    pu_riscv_mmu_arbiter_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_last_d;
    logic            r_lock_hold;
    logic            r_vreq;
    logic [XLEN-1:0] r_vadr;
    logic [2:0]      r_vsize;
    logic            r_vlock;
    logic [2:0]      r_vprot;
    logic            r_vwe;
    logic [XLEN-1:0] r_vd;

    logic w_idle;
    logic w_pick_d;
    logic w_gnt_i;
    logic w_gnt_d;

    assign w_idle   = (r_state == IDLE);
    // Data wins a tie while a locked sequence is open or when instruction went last.
    assign w_pick_d = bus.dreq_i & (~bus.ireq_i | r_lock_hold | ~r_last_d);
    assign w_gnt_d  = w_idle & ~clr_i & w_pick_d;
    assign w_gnt_i  = w_idle & ~clr_i & bus.ireq_i & ~w_pick_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_last_d    <= 1'b1;
            r_lock_hold <= 1'b0;
            r_vreq      <= 1'b0;
            r_vadr      <= '0;
            r_vsize     <= '0;
            r_vlock     <= 1'b0;
            r_vprot     <= '0;
            r_vwe       <= 1'b0;
            r_vd        <= '0;
        end else if (clr_i) begin
            r_state     <= IDLE;
            r_vreq      <= 1'b0;
            r_lock_hold <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!bus.dlock_i) r_lock_hold <= 1'b0;
                    if (w_gnt_d) begin
                        r_state     <= GNT_D;
                        r_vreq      <= 1'b1;
                        r_last_d    <= 1'b1;
                        r_lock_hold <= 1'b0;
                        r_vadr      <= bus.dadr_i;
                        r_vsize     <= bus.dsize_i;
                        r_vlock     <= bus.dlock_i;
                        r_vprot     <= bus.dprot_i;
                        r_vwe       <= bus.dwe_i;
                        r_vd        <= bus.dd_i;
                    end else if (w_gnt_i) begin
                        r_state  <= GNT_I;
                        r_vreq   <= 1'b1;
                        r_last_d <= 1'b0;
                        r_vadr   <= bus.iadr_i;
                        r_vsize  <= bus.isize_i;
                        r_vlock  <= 1'b0;
                        r_vprot  <= bus.iprot_i;
                        r_vwe    <= 1'b0;
                        r_vd     <= '0;
                    end
                end
                GNT_I: begin
                    if (bus.vack_i) begin
                        r_state <= IDLE;
                        r_vreq  <= 1'b0;
                    end
                end
                GNT_D: begin
                    if (bus.vack_i) begin
                        r_state     <= IDLE;
                        r_vreq      <= 1'b0;
                        r_lock_hold <= r_vlock & bus.dlock_i;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_vreq  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.iack_o  = bus.vack_i & ~clr_i & (r_state == GNT_I);
    assign bus.dack_o  = bus.vack_i & ~clr_i & (r_state == GNT_D);
    assign bus.iq_o    = bus.vq_i;
    assign bus.dq_o    = bus.vq_i;

    assign bus.vreq_o  = r_vreq;
    assign bus.vadr_o  = r_vadr;
    assign bus.vsize_o = r_vsize;
    assign bus.vlock_o = r_vlock;
    assign bus.vprot_o = r_vprot;
    assign bus.vwe_o   = r_vwe;
    assign bus.vd_o    = r_vd;
endmodule

// File: tb/tb_pu_riscv_mmu_arbiter.sv
// Randomized bench for pu_riscv_mmu_arbiter: requester/MMU drivers, a transaction-level
// arbitration model, and per-side scoreboards popped on each forwarded acknowledge.
module tb_pu_riscv_mmu_arbiter;
    localparam int XLEN = 64;

    typedef struct packed {
        logic [XLEN-1:0] adr;
        logic [2:0]      size;
        logic [2:0]      prot;
        logic            we;
        logic [XLEN-1:0] d;
        logic            lock;
    } req_t;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    logic clr_i  = 1'b0;

    pu_riscv_mmu_arbiter_if #(.XLEN(XLEN)) bus ();

    pu_riscv_mmu_arbiter #(.XLEN(XLEN)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    req_t i_exp[$];
    req_t d_exp[$];
    int   i_acks = 0;
    int   d_acks = 0;

    bit   m_busy   = 1'b0;
    bit   m_side   = 1'b0;
    bit   m_last_d = 1'b1;
    bit   m_lock   = 1'b0;
    req_t m_attr   = '0;

    logic [XLEN-1:0] mmu_q = '0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_vreq"}, 64'(bus.vreq_o), 64'(0));
        check({tag, "_vadr"}, bus.vadr_o, 64'(0));
        check({tag, "_vattr"}, 64'({bus.vsize_o, bus.vprot_o, bus.vwe_o, bus.vlock_o}), 64'(0));
        check({tag, "_vd"}, bus.vd_o, 64'(0));
        check({tag, "_acks"}, 64'({bus.iack_o, bus.dack_o}), 64'(0));
    endtask

    // Reference model: arbitration rules applied once per cycle, plus scoreboard pops on acks.
    always @(negedge clk) begin : monitor
        bit   old_lock;
        bit   pick_d;
        bit   exp_i;
        bit   exp_d;
        req_t e;
        if (!rst_ni) begin
            m_busy   = 1'b0;
            m_last_d = 1'b1;
            m_lock   = 1'b0;
            i_exp.delete();
            d_exp.delete();
        end else begin
            check("vreq", 64'(bus.vreq_o), 64'(m_busy));
            if (m_busy) begin
                check("vadr", bus.vadr_o, m_attr.adr);
                check("vattr", 64'({bus.vsize_o, bus.vprot_o, bus.vwe_o, bus.vlock_o}),
                      64'({m_attr.size, m_attr.prot, m_attr.we, m_attr.lock}));
                check("vd", bus.vd_o, m_attr.d);
            end
            exp_i = m_busy && !m_side && bus.vack_i && !clr_i;
            exp_d = m_busy &&  m_side && bus.vack_i && !clr_i;
            check("iack", 64'(bus.iack_o), 64'(exp_i));
            check("dack", 64'(bus.dack_o), 64'(exp_d));

            if (bus.iack_o) begin
                i_acks++;
                if (i_exp.size() == 0) check("i_sb_pending", 64'(i_exp.size()), 64'(1));
                else begin
                    e = i_exp.pop_front();
                    check("i_adr", bus.vadr_o, e.adr);
                    check("i_attr", 64'({bus.vsize_o, bus.vprot_o, bus.vwe_o, bus.vlock_o}),
                          64'({e.size, e.prot, 2'b00}));
                    check("i_vd", bus.vd_o, 64'(0));
                    check("iq", bus.iq_o, mmu_q);
                end
            end
            if (bus.dack_o) begin
                d_acks++;
                if (d_exp.size() == 0) check("d_sb_pending", 64'(d_exp.size()), 64'(1));
                else begin
                    e = d_exp.pop_front();
                    check("d_adr", bus.vadr_o, e.adr);
                    check("d_attr", 64'({bus.vsize_o, bus.vprot_o, bus.vwe_o, bus.vlock_o}),
                          64'({e.size, e.prot, e.we, e.lock}));
                    check("d_vd", bus.vd_o, e.d);
                    check("dq", bus.dq_o, mmu_q);
                end
            end

            old_lock = m_lock;
            if (clr_i) begin
                m_busy = 1'b0;
                m_lock = 1'b0;
            end else if (m_busy) begin
                if (bus.vack_i) begin
                    m_busy = 1'b0;
                    if (m_side) m_lock = m_attr.lock & bus.dlock_i;
                end
            end else begin
                if (!bus.dlock_i) m_lock = 1'b0;
                if (bus.ireq_i || bus.dreq_i) begin
                    pick_d   = bus.dreq_i && (!bus.ireq_i || old_lock || !m_last_d);
                    m_busy   = 1'b1;
                    m_side   = pick_d;
                    m_last_d = pick_d;
                    if (pick_d) begin
                        m_attr = '{bus.dadr_i, bus.dsize_i, bus.dprot_i, bus.dwe_i, bus.dd_i, bus.dlock_i};
                        m_lock = 1'b0;
                    end else begin
                        m_attr = '{bus.iadr_i, bus.isize_i, bus.iprot_i, 1'b0, 64'(0), 1'b0};
                    end
                end
            end
        end
    end

    int i_seen = 0, d_seen = 0, i_gap = 0, d_gap = 0, lat = 0;
    int gap_max = 0, lock_pct = 0;
    bit i_en = 1'b0, d_en = 1'b0, clr_on = 1'b0, stray_on = 1'b0;

    task automatic issue_i();
        req_t r;
        r.adr  = {$urandom, $urandom};
        r.size = 3'($urandom_range(0, 7));
        r.prot = 3'($urandom_range(0, 7));
        r.we   = 1'b0;
        r.d    = '0;
        r.lock = 1'b0;
        bus.ireq_i  = 1'b1;
        bus.iadr_i  = r.adr;
        bus.isize_i = r.size;
        bus.iprot_i = r.prot;
        i_exp.push_back(r);
    endtask

    task automatic issue_d();
        req_t r;
        r.adr  = {$urandom, $urandom};
        r.size = 3'($urandom_range(0, 7));
        r.prot = 3'($urandom_range(0, 7));
        r.we   = 1'($urandom_range(0, 1));
        r.d    = {$urandom, $urandom};
        r.lock = ($urandom_range(0, 99) < lock_pct);
        bus.dreq_i  = 1'b1;
        bus.dadr_i  = r.adr;
        bus.dsize_i = r.size;
        bus.dprot_i = r.prot;
        bus.dwe_i   = r.we;
        bus.dd_i    = r.d;
        bus.dlock_i = r.lock;
        d_exp.push_back(r);
    endtask

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        if (i_acks != i_seen) begin
            i_seen     = i_acks;
            bus.ireq_i = 1'b0;
            i_gap      = $urandom_range(0, gap_max);
        end
        if (d_acks != d_seen) begin
            d_seen      = d_acks;
            bus.dreq_i  = 1'b0;
            bus.dlock_i = 1'b0;
            d_gap       = $urandom_range(0, gap_max);
        end
        if (!bus.ireq_i && i_en) begin
            if (i_gap > 0) i_gap--;
            else issue_i();
        end
        if (!bus.dreq_i && d_en) begin
            if (d_gap > 0) d_gap--;
            else issue_d();
        end

        mmu_q       = {$urandom, $urandom};
        bus.vq_i    = mmu_q;
        bus.vack_i  = 1'b0;
        if (bus.vreq_o) begin
            if (lat == 0) bus.vack_i = 1'b1;
            else lat--;
        end else begin
            lat = $urandom_range(0, 3);
            if (stray_on && $urandom_range(0, 5) == 0) bus.vack_i = 1'b1;
        end
        clr_i = clr_on && ($urandom_range(0, 11) == 0);
    endtask

    task automatic quiet_inputs();
        bus.ireq_i  = 1'b0;  bus.iadr_i = '0; bus.isize_i = '0; bus.iprot_i = '0;
        bus.dreq_i  = 1'b0;  bus.dadr_i = '0; bus.dsize_i = '0; bus.dprot_i = '0;
        bus.dlock_i = 1'b0;  bus.dwe_i  = 1'b0; bus.dd_i  = '0;
        bus.vack_i  = 1'b0;  bus.vq_i   = '0;
        clr_i       = 1'b0;
        i_seen = i_acks; d_seen = d_acks; i_gap = 0; d_gap = 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) drive_cycle();
    endtask

    initial begin
        bit found;
        quiet_inputs();
        @(posedge clk);
        #1;
        check_reset_outs("rst");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Back-to-back ties from reset: instruction first, then strict alternation.
        i_en = 1'b1; d_en = 1'b1; gap_max = 0; lock_pct = 0;
        run(40);

        // Mostly locked data traffic competing with continuous fetches.
        lock_pct = 80;
        run(300);

        // Random gaps, flushes and stray MMU acks.
        gap_max = 2; lock_pct = 40; clr_on = 1'b1; stray_on = 1'b1;
        run(600);

        // Asynchronous reset in the middle of an instruction grant.
        d_en = 1'b0; clr_on = 1'b0; stray_on = 1'b0; lock_pct = 0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            drive_cycle();
            if (bus.vreq_o && m_busy && !m_side) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL wait_gnt_i: no instruction grant within 200 cycles, required one");
        end
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outs("async_rst");
        quiet_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;

        i_en = 1'b1; d_en = 1'b1; gap_max = 0;
        run(30);
        gap_max = 1; lock_pct = 50; clr_on = 1'b1; stray_on = 1'b1;
        run(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
